// File: rtl/can_sched_pkg.sv
// CAN transmit scheduler shared definitions:
// FSM state enum, parameter defaults and index/counter widths.
package can_sched_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        XMIT = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam int DEF_NMBOX       = 4;
    localparam int DEF_MAX_RETRY   = 3;
    localparam int DEF_TIMEOUT_CYC = 50000;
    localparam int DEF_IFS_CYC     = 16;

    localparam int IDX_W = 2;
    localparam int CNT_W = 16;
    localparam int RTY_W = 8;

endpackage

// File: rtl/can_prio_enc.sv
// Lowest-index-first priority encoder over mailbox valid flags.
// Ports: req (flags in), any (some flag set), idx (lowest set index).
module can_prio_enc
    import can_sched_pkg::*;
#(
    parameter int N = DEF_NMBOX
) (
    input  logic [N-1:0]     req,
    output logic             any,
    output logic [IDX_W-1:0] idx
);

    always_comb begin
        any = |req;
        idx = '0;
        // Walk downward so the lowest set index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/can_tx_scheduler.sv
// Fixed-priority CAN transmit mailbox scheduler with retry, timeout and
// inter-frame gap. Ports: CLOCK_SIGNAL_IN/RESET, mailbox write port
// (wr_en/wr_idx/wr_data/wr_ack/mbox_full), controller handshake
// (send_data/transmit_data/tx_done/tx_err), reports (sent_*/fail_*), busy.
module can_tx_scheduler
    import can_sched_pkg::*;
#(
    parameter int NMBOX       = DEF_NMBOX,
    parameter int MAX_RETRY   = DEF_MAX_RETRY,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int IFS_CYC     = DEF_IFS_CYC
) (
    input  logic             CLOCK_SIGNAL_IN,
    input  logic             RESET,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [7:0]       wr_data,
    output logic             wr_ack,
    output logic [NMBOX-1:0] mbox_full,
    output logic             send_data,
    output logic [7:0]       transmit_data,
    input  logic             tx_done,
    input  logic             tx_err,
    output logic             sent_pulse,
    output logic [IDX_W-1:0] sent_idx,
    output logic             fail_pulse,
    output logic [IDX_W-1:0] fail_idx,
    output logic             busy
);

    state_t           state, state_d;
    logic [7:0]       mbox_data [NMBOX];
    logic [IDX_W-1:0] cur_idx, cur_d;
    logic [RTY_W-1:0] retry_cnt, retry_d, retry_inc;
    logic [CNT_W-1:0] tmo_cnt, tmo_d;
    logic [CNT_W-1:0] gap_cnt, gap_d;
    logic [NMBOX-1:0] full_d;
    logic             send_d, sp_d, fp_d;
    logic [7:0]       txd_d;
    logic [IDX_W-1:0] si_d, fi_d;
    logic             sel_any;
    logic [IDX_W-1:0] sel_idx;
    logic             wr_ok;

    can_prio_enc #(.N(NMBOX)) u_enc (
        .req (mbox_full),
        .any (sel_any),
        .idx (sel_idx)
    );

    assign busy  = (state != IDLE);
    assign wr_ok = wr_en && (int'(wr_idx) < NMBOX) && !mbox_full[wr_idx];

    assign retry_inc = (retry_cnt == '1) ? retry_cnt : retry_cnt + 1'b1;

    always_ff @(posedge CLOCK_SIGNAL_IN or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        full_d  = mbox_full;
        send_d  = send_data;
        txd_d   = transmit_data;
        cur_d   = cur_idx;
        retry_d = retry_cnt;
        tmo_d   = tmo_cnt;
        gap_d   = gap_cnt;
        sp_d    = 1'b0;
        si_d    = sent_idx;
        fp_d    = 1'b0;
        fi_d    = fail_idx;

        if (wr_ok) full_d[wr_idx] = 1'b1;

        unique case (state)
            IDLE: begin
                if (sel_any) begin
                    state_d = XMIT;
                    send_d  = 1'b1;
                    txd_d   = mbox_data[sel_idx];
                    cur_d   = sel_idx;
                    tmo_d   = '0;
                    // A different mailbox starts with a fresh retry budget.
                    if (sel_idx != cur_idx) retry_d = '0;
                end
            end
            XMIT: begin
                if (tx_done) begin
                    full_d[cur_idx] = 1'b0;
                    sp_d    = 1'b1;
                    si_d    = cur_idx;
                    retry_d = '0;
                    send_d  = 1'b0;
                    gap_d   = '0;
                    state_d = GAP;
                end else if (tx_err ||
                             tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    send_d  = 1'b0;
                    gap_d   = '0;
                    state_d = GAP;
                    if (retry_inc >= RTY_W'(MAX_RETRY)) begin
                        full_d[cur_idx] = 1'b0;
                        fp_d    = 1'b1;
                        fi_d    = cur_idx;
                        retry_d = '0;
                    end else begin
                        retry_d = retry_inc;
                    end
                end else if (tmo_cnt != '1) begin
                    tmo_d = tmo_cnt + 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt >= CNT_W'(IFS_CYC - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_cnt + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_SIGNAL_IN or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < NMBOX; i++) mbox_data[i] <= '0;
            mbox_full     <= '0;
            wr_ack        <= 1'b0;
            send_data     <= 1'b0;
            transmit_data <= '0;
            cur_idx       <= '0;
            retry_cnt     <= '0;
            tmo_cnt       <= '0;
            gap_cnt       <= '0;
            sent_pulse    <= 1'b0;
            sent_idx      <= '0;
            fail_pulse    <= 1'b0;
            fail_idx      <= '0;
        end else begin
            if (wr_ok) mbox_data[wr_idx] <= wr_data;
            mbox_full     <= full_d;
            wr_ack        <= wr_ok;
            send_data     <= send_d;
            transmit_data <= txd_d;
            cur_idx       <= cur_d;
            retry_cnt     <= retry_d;
            tmo_cnt       <= tmo_d;
            gap_cnt       <= gap_d;
            sent_pulse    <= sp_d;
            sent_idx      <= si_d;
            fail_pulse    <= fp_d;
            fail_idx      <= fi_d;
        end
    end

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Self-checking bench for can_tx_scheduler: a table of per-cycle vectors
// plus directed sequences for retry, timeout, preemption and reset.
module tb_can_tx_scheduler;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [7:0] wr_data;
    logic       wr_ack;
    logic [3:0] mbox_full;
    logic       send_data;
    logic [7:0] transmit_data;
    logic       tx_done;
    logic       tx_err;
    logic       sent_pulse;
    logic [1:0] sent_idx;
    logic       fail_pulse;
    logic [1:0] fail_idx;
    logic       busy;

    int nchk = 0;
    int nerr = 0;

    can_tx_scheduler #(
        .NMBOX       (4),
        .MAX_RETRY   (3),
        .TIMEOUT_CYC (100),
        .IFS_CYC     (16)
    ) dut (
        .CLOCK_SIGNAL_IN (clk),
        .RESET           (rst),
        .wr_en           (wr_en),
        .wr_idx          (wr_idx),
        .wr_data         (wr_data),
        .wr_ack          (wr_ack),
        .mbox_full       (mbox_full),
        .send_data       (send_data),
        .transmit_data   (transmit_data),
        .tx_done         (tx_done),
        .tx_err          (tx_err),
        .sent_pulse      (sent_pulse),
        .sent_idx        (sent_idx),
        .fail_pulse      (fail_pulse),
        .fail_idx        (fail_idx),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       we;
        logic [1:0] widx;
        logic [7:0] wdat;
        logic       done;
        logic       err;
        int         reps;
        logic       e_ack;
        logic [3:0] e_full;
        logic       e_send;
        logic [7:0] e_txd;
        logic       e_sent;
        logic [1:0] e_sidx;
        logic       e_busy;
    } vec_t;

    vec_t vec [12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] i, input logic [7:0] d);
        wr_en = 1'b1; wr_idx = i; wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic err_pulse();
        tx_err = 1'b1;
        step();
        tx_err = 1'b0;
    endtask

    task automatic done_pulse();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    task automatic wait_send(input string nm);
        int n = 0;
        while (!send_data && n < 64) begin
            step();
            n++;
        end
        chk(nm, 32'(send_data), 32'd1);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 64) begin
            step();
            n++;
        end
        chk(nm, 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_data = '0;
        tx_done = 1'b0; tx_err = 1'b0;

        vec[0]  = '{1, 2, 8'hE3, 0, 0, 1,  1, 4'h4, 0, 8'h00, 0, 0, 0};
        vec[1]  = '{1, 2, 8'h55, 0, 0, 1,  0, 4'h4, 1, 8'hE3, 0, 0, 1};
        vec[2]  = '{0, 0, 8'h00, 0, 0, 1,  0, 4'h4, 1, 8'hE3, 0, 0, 1};
        vec[3]  = '{1, 1, 8'h77, 0, 0, 1,  1, 4'h6, 1, 8'hE3, 0, 0, 1};
        vec[4]  = '{0, 0, 8'h00, 0, 0, 1,  0, 4'h6, 1, 8'hE3, 0, 0, 1};
        vec[5]  = '{0, 0, 8'h00, 1, 0, 1,  0, 4'h2, 0, 8'hE3, 1, 2, 1};
        vec[6]  = '{0, 0, 8'h00, 0, 0, 15, 0, 4'h2, 0, 8'hE3, 0, 2, 1};
        vec[7]  = '{0, 0, 8'h00, 0, 1, 1,  0, 4'h2, 0, 8'hE3, 0, 2, 0};
        vec[8]  = '{0, 0, 8'h00, 0, 0, 1,  0, 4'h2, 1, 8'h77, 0, 2, 1};
        vec[9]  = '{0, 0, 8'h00, 1, 1, 1,  0, 4'h0, 0, 8'h77, 1, 1, 1};
        vec[10] = '{0, 0, 8'h00, 0, 0, 15, 0, 4'h0, 0, 8'h77, 0, 1, 1};
        vec[11] = '{0, 0, 8'h00, 0, 0, 1,  0, 4'h0, 0, 8'h77, 0, 1, 0};

        // Reset state
        #3;
        chk("rst.send", 32'(send_data), 0);
        chk("rst.ack", 32'(wr_ack), 0);
        chk("rst.full", 32'(mbox_full), 0);
        chk("rst.txd", 32'(transmit_data), 0);
        chk("rst.busy", 32'(busy), 0);
        chk("rst.pulses", {30'd0, sent_pulse, fail_pulse}, 0);
        chk("rst.idx", {28'd0, sent_idx, fail_idx}, 0);
        step();
        step();
        rst = 1'b0;

        // Table: single frame, rejected write, ignored strobes, done+err
        for (int r = 0; r < 12; r++) begin
            for (int k = 0; k < vec[r].reps; k++) begin
                wr_en = vec[r].we; wr_idx = vec[r].widx;
                wr_data = vec[r].wdat;
                tx_done = vec[r].done; tx_err = vec[r].err;
                step();
                chk($sformatf("v%0d.ack", r), 32'(wr_ack), 32'(vec[r].e_ack));
                chk($sformatf("v%0d.full", r), 32'(mbox_full),
                    32'(vec[r].e_full));
                chk($sformatf("v%0d.send", r), 32'(send_data),
                    32'(vec[r].e_send));
                chk($sformatf("v%0d.txd", r), 32'(transmit_data),
                    32'(vec[r].e_txd));
                chk($sformatf("v%0d.sent", r), 32'(sent_pulse),
                    32'(vec[r].e_sent));
                chk($sformatf("v%0d.sidx", r), 32'(sent_idx),
                    32'(vec[r].e_sidx));
                chk($sformatf("v%0d.busy", r), 32'(busy), 32'(vec[r].e_busy));
            end
            wr_en = 1'b0; tx_done = 1'b0; tx_err = 1'b0;
        end

        // Back-to-back writes: IDLE captures mbox3 before mbox1 arrives
        wr(2'd3, 8'h11);
        wr(2'd1, 8'h22);
        chk("b2b.send1", 32'(send_data), 1);
        chk("b2b.txd1", 32'(transmit_data), 32'h11);
        done_pulse();
        chk("b2b.sidx1", {31'd0, sent_pulse, sent_idx} , 32'h7);
        wait_send("b2b.wait2");
        chk("b2b.txd2", 32'(transmit_data), 32'h22);
        done_pulse();
        chk("b2b.sidx2", {31'd0, sent_pulse, sent_idx}, 32'h5);
        wait_idle("b2b.idle");

        // Three errors on mbox0 drop the frame
        wr(2'd0, 8'hA5);
        chk("rty.ack", 32'(wr_ack), 1);
        for (int a = 0; a < 3; a++) begin
            wait_send($sformatf("rty.xmit%0d", a));
            chk($sformatf("rty.txd%0d", a), 32'(transmit_data), 32'hA5);
            err_pulse();
            chk($sformatf("rty.fail%0d", a), 32'(fail_pulse),
                32'(a == 2));
            chk($sformatf("rty.send%0d", a), 32'(send_data), 0);
        end
        chk("rty.fidx", 32'(fail_idx), 0);
        chk("rty.full", 32'(mbox_full), 0);
        wait_idle("rty.idle");
        step();
        chk("rty.nosend", 32'(send_data), 0);

        // Timeout counts as one attempt
        wr(2'd1, 8'h3C);
        wait_send("tmo.xmit");
        begin
            int n = 0;
            while (send_data && n < 300) begin
                step();
                n++;
            end
            chk("tmo.len", 32'(n), 32'd100);
        end
        chk("tmo.fail", 32'(fail_pulse), 0);
        chk("tmo.full", 32'(mbox_full), 32'h2);
        wait_send("tmo.xmit2");
        err_pulse();
        chk("tmo.fail2", 32'(fail_pulse), 0);
        wait_send("tmo.xmit3");
        err_pulse();
        chk("tmo.fail3", {29'd0, fail_pulse, fail_idx}, 32'h5);
        wait_idle("tmo.idle");

        // Preemption during GAP resets the retry budget of mbox2
        wr(2'd2, 8'h42);
        wait_send("pre.xmit");
        err_pulse();
        wr(2'd0, 8'h99);
        chk("pre.ack", 32'(wr_ack), 1);
        wait_send("pre.xmit0");
        chk("pre.txd0", 32'(transmit_data), 32'h99);
        done_pulse();
        chk("pre.sent0", {31'd0, sent_pulse, sent_idx}, 32'h4);
        for (int a = 0; a < 3; a++) begin
            wait_send($sformatf("pre.x2_%0d", a));
            chk($sformatf("pre.txd2_%0d", a), 32'(transmit_data), 32'h42);
            err_pulse();
            chk($sformatf("pre.fail%0d", a), 32'(fail_pulse),
                32'(a == 2));
        end
        chk("pre.fidx", 32'(fail_idx), 2);
        wait_idle("pre.idle");

        // Asynchronous reset mid-XMIT
        wr(2'd3, 8'h5A);
        wait_send("ar.xmit");
        #3 rst = 1'b1;
        #1;
        chk("ar.send", 32'(send_data), 0);
        chk("ar.full", 32'(mbox_full), 0);
        chk("ar.busy", 32'(busy), 0);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("ar.pulses", {30'd0, sent_pulse, fail_pulse}, 0);
        rst = 1'b0;
        step();
        chk("ar.pulses2", {30'd0, sent_pulse, fail_pulse}, 0);
        wr(2'd0, 8'h10);
        chk("ar.ack1", 32'(wr_ack), 1);
        wr(2'd0, 8'h20);
        chk("ar.ack2", 32'(wr_ack), 0);
        chk("ar.txd", 32'(transmit_data), 32'h10);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/can_tx_scheduler.md
CAN_TX_SCHEDULER -- requirements
Module: can_tx_scheduler

Interface
REQ-001 SHALL have parameter NMBOX, default 4: number of transmit mailboxes, fixed priority, index 0 highest.
REQ-002 SHALL have parameter MAX_RETRY, default 3: attempts per frame before the frame is dropped.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50000: XMIT cycles without completion before the attempt counts as failed.
REQ-004 SHALL have parameter IFS_CYC, default 16 (legal range >=1): idle cycles between attempts.
REQ-005 SHALL have one clock and an asynchronous, active-high reset; the ports are named CLOCK_SIGNAL_IN and RESET.
REQ-006 SHALL have port CLOCK_SIGNAL_IN, input, 1 bit: system clock; all state updates on its rising edge.
REQ-007 SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port wr_en, input, 1 bit: mailbox write strobe.
REQ-009 SHALL have port wr_idx, input, 2 bits: target mailbox index.
REQ-010 SHALL have port wr_data, input, 8 bits: payload byte for the mailbox.
REQ-011 SHALL have port wr_ack, output, 1 bit: registered; high the cycle after an accepted write.
REQ-012 SHALL have port mbox_full, output, 4 bits: per-mailbox valid flags.
REQ-013 SHALL have port send_data, output, 1 bit: level transmit request to the CAN controller.
REQ-014 SHALL have port transmit_data, output, 8 bits: byte to the controller; stable while send_data is high.
REQ-015 SHALL have port tx_done, input, 1 bit: one-cycle pulse from the controller on successful frame.
REQ-016 SHALL have port tx_err, input, 1 bit: one-cycle pulse on lost arbitration, missing ACK or bus error.
REQ-017 SHALL have port sent_pulse, output, 1 bit, with sent_idx, output, 2 bits: one-cycle success report.
REQ-018 SHALL have port fail_pulse, output, 1 bit, with fail_idx, output, 2 bits: one-cycle drop report.
REQ-019 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-020 SHALL accept a write only when mbox_full[wr_idx]==0: latch data, set the flag, pulse wr_ack; a write to a full mailbox SHALL be ignored with wr_ack low.
REQ-021 SHALL implement an FSM with states IDLE, XMIT and GAP.
REQ-022 In IDLE with any mbox_full bit set, SHALL select the lowest set index, load transmit_data and cur_idx, raise send_data and enter XMIT on the same edge.
REQ-023 A mailbox written at edge N SHALL be eligible at edge N+1 at the earliest; from IDLE, send_data SHALL be high after edge N+1.
REQ-024 In XMIT, send_data SHALL stay high and a 16-bit timeout counter SHALL increment each cycle.
REQ-025 On tx_done in XMIT: clear mbox_full[cur_idx], pulse sent_pulse and sent_idx, zero retry_cnt, drop send_data, enter GAP.
REQ-026 On tx_err or timeout==TIMEOUT_CYC-1 in XMIT: increment retry_cnt and drop send_data.
REQ-027 After the REQ-026 increment, if retry_cnt reaches MAX_RETRY, SHALL clear the mailbox, pulse fail_pulse and fail_idx, and zero retry_cnt; in all REQ-026 cases SHALL then enter GAP.
REQ-028 tx_done and tx_err in the same cycle SHALL be treated as done.
REQ-029 tx_done and tx_err outside XMIT SHALL be ignored.
REQ-030 GAP SHALL last exactly IFS_CYC cycles, then return to IDLE.
REQ-031 A retried frame SHALL re-arbitrate; a higher-priority mailbox SHALL preempt it, and retry_cnt SHALL reset when the selected index differs from the last attempted index.
REQ-032 The mailbox in transmission SHALL remain full, so writes to it SHALL be rejected until it is cleared.
REQ-033 Counters SHALL saturate, not wrap; the timeout counter SHALL be cleared on XMIT entry.

Reset
REQ-034 While RESET is high, SHALL immediately force: state IDLE; send_data, wr_ack, sent_pulse, fail_pulse and busy 0; mbox_full 0; transmit_data, sent_idx and fail_idx 0; all counters 0.
REQ-035 Reset mid-XMIT SHALL discard the frame with no sent_pulse or fail_pulse.

Structure
REQ-036 Package can_sched_pkg SHALL hold the state enum, the parameter defaults and the index width constant.
REQ-037 Sub-module can_prio_enc SHALL implement the combinational lowest-index-first encoder, with outputs any and idx.

Verification
REQ-038 Write mbox2=0xE3 from IDLE: wr_ack at N+1, send_data high at N+1 with transmit_data 0xE3; tx_done 5 cycles later gives sent_pulse with sent_idx 2, mbox_full 0000, busy low after 16 GAP cycles.
REQ-039 Write mbox3=0x11 and mbox1=0x22 in consecutive cycles from IDLE: 0x11 sends first (IDLE already captured it), then 0x22.
REQ-040 With MAX_RETRY=3, mbox0=0xA5 gets tx_err three times: three XMIT entries, then fail_pulse with fail_idx 0 and mbox_full[0]=0.
REQ-041 With TIMEOUT_CYC=100 and no response: send_data falls after 100 cycles; the attempt counts as a retry.
REQ-042 mbox2 fails once, then mbox0 is written during GAP: mbox0 sends next, and mbox2 resumes with retry_cnt=0.
REQ-043 RESET asserted mid-XMIT: send_data falls asynchronously, mbox_full 0000, no pulses; a write to a full mailbox gets no wr_ack.
